// File: rtl/decode_pkg.sv
// Shared constants and entry layout for the decode/issue queue.
// The entry struct depends on module parameters, so it is built by a macro.
`define DEC_ENTRY_T(nf, rwid) \
    struct packed { \
        logic [(nf)-1:0]   fu_sel; \
        logic [(rwid)-1:0] rw; \
        logic [(rwid)-1:0] ra; \
        logic [(rwid)-1:0] rb; \
    }

package decode_pkg;
    localparam int FU_ADD = 0;
    localparam int FU_MUL = 1;

    function automatic int inst_w(input int op_w, input int reg_w);
        return op_w + 3 * reg_w;
    endfunction
endpackage

// File: rtl/dec_fifo.sv
// Generic synchronous FIFO with occupancy count, flush and async reset.
// Storage is left uninitialised; only pointers and count are reset.
module dec_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/decode_issue_queue.sv
// Decodes {op, Rw, Ra, Rb} words into a small in-order queue and
// issues the head entry to the functional unit selected by its opcode.
module decode_issue_queue
    import decode_pkg::*;
#(
    parameter int REG_W  = 3,
    parameter int OP_W   = 1,
    parameter int NUM_FU = 2,
    parameter int DEPTH  = 4,
    localparam int INST_W = inst_w(OP_W, REG_W),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] inst,
    output logic              out_valid,
    output logic [NUM_FU-1:0] out_fu_sel,
    output logic [REG_W-1:0]  out_ra,
    output logic [REG_W-1:0]  out_rb,
    output logic [REG_W-1:0]  out_rw,
    input  logic [NUM_FU-1:0] fu_ready,
    output logic              illegal,
    output logic [CW-1:0]     count
);
    typedef `DEC_ENTRY_T(NUM_FU, REG_W) dec_entry_t;
    localparam int EW = $bits(dec_entry_t);

    logic [OP_W-1:0] op;
    logic            legal;
    logic            accept;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    dec_entry_t      wr_entry;
    dec_entry_t      head;
    logic [EW-1:0]   head_bits;

    assign op     = inst[INST_W-1 -: OP_W];
    assign legal  = ({1'b0, op} < (OP_W + 1)'(NUM_FU));
    assign accept = in_valid && in_ready;
    assign push   = accept && legal;

    always_comb begin
        wr_entry        = '0;
        wr_entry.fu_sel = NUM_FU'(1) << op;
        wr_entry.rw     = inst[3*REG_W-1 -: REG_W];
        wr_entry.ra     = inst[2*REG_W-1 -: REG_W];
        wr_entry.rb     = inst[REG_W-1:0];
    end

    dec_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (head_bits),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // No pass-through when full: a same-cycle dequeue does not free a slot.
    assign in_ready   = !full && !flush;
    assign head       = dec_entry_t'(head_bits);
    assign out_valid  = !empty;
    assign out_fu_sel = out_valid ? head.fu_sel : '0;
    assign out_rw     = out_valid ? head.rw : '0;
    assign out_ra     = out_valid ? head.ra : '0;
    assign out_rb     = out_valid ? head.rb : '0;
    assign pop        = out_valid && |(out_fu_sel & fu_ready) && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal <= 1'b0;
        else if (flush)
            illegal <= 1'b0;
        else
            illegal <= accept && !legal;
    end
endmodule
